// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_arb_pkg
// Brief    : Shared constants for the register-file write-port arbiter:
//            default address/data widths, grant encoding and entry width.
// Revision : 1.0 - initial release
// ============================================================================
package rf_arb_pkg;

   // Default register address and data widths
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;

   // Width of one buffered I/O write {addr, data} at the default widths
   localparam int ENTRY_W = DEF_ADDR_W + DEF_DATA_W;

   // Grant encoding: who owns the write port this cycle
   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_CPU  = 2'd1;
   localparam logic [1:0] GNT_IO   = 2'd2;

endpackage : rf_arb_pkg
`default_nettype wire

// File: rtl/rf_write_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rf_wr_fifo
// Brief    : Synchronous FIFO buffering I/O register writes. Asynchronous
//            active-high reset flushes all entries. Head entry is visible
//            combinationally so the arbiter can drive it straight to the
//            register file in the cycle it is popped.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 12,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             w_do_push;
   logic             w_do_pop;

   // A push is ignored when full and a pop is ignored when empty
   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign w_do_push = push_i && !full_o;
   assign w_do_pop  = pop_i && !empty_o;
   assign head_o    = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // Storage array; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule : rf_wr_fifo
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Brief    : Shares the single register-file write port between CPU
//            writeback and buffered I/O writes. I/O writes drain into idle
//            write cycles; after STARVE_MAX consecutive CPU wins with I/O
//            pending, the CPU is stalled for one cycle to force a drain.
// Macro    : RF_ARB_STATS_EN - adds saturating 16-bit activity counters
//            (stat_cpu_wr, stat_io_wr, stat_stall).
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
   import rf_arb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 3,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cpu_we,
   input  logic [ADDR_W-1:0]             cpu_wa,
   input  logic [DATA_W-1:0]             cpu_wd,
   output logic                          cpu_stall,
   input  logic                          io_valid,
   output logic                          io_ready,
   input  logic [ADDR_W-1:0]             io_wa,
   input  logic [DATA_W-1:0]             io_wd,
   output logic                          rf_we,
   output logic [ADDR_W-1:0]             rf_wa,
   output logic [DATA_W-1:0]             rf_wd,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef RF_ARB_STATS_EN
   ,
   output logic [15:0]                   stat_cpu_wr,
   output logic [15:0]                   stat_io_wr,
   output logic [15:0]                   stat_stall
`endif
);

   localparam int c_ENTRY_W  = ADDR_W + DATA_W;
   localparam int c_STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);

   logic [c_ENTRY_W-1:0]  w_head;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_stall;
   logic [1:0]            w_gnt;
   logic [c_STARVE_W-1:0] starve_cnt_q;
   logic [c_STARVE_W-1:0] starve_cnt_d;

   // Acceptance uses the pre-edge count, so a same-cycle pop never frees a
   // slot for the offered write. Writes to r0 complete the handshake but are
   // dropped since r0 is hardwired to zero.
   assign io_ready = !w_full;
   assign w_push   = io_valid && !w_full && (io_wa != '0);

   rf_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (c_ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .wdata_i ({io_wa, io_wd}),
      .head_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (fifo_count)
   );

   // Grant decision and next starvation count
   always_comb begin
      w_gnt        = GNT_NONE;
      w_pop        = 1'b0;
      w_stall      = 1'b0;
      starve_cnt_d = starve_cnt_q;
      if (w_empty) begin
         w_gnt        = cpu_we ? GNT_CPU : GNT_NONE;
         starve_cnt_d = '0;
      end else if (!cpu_we) begin
         w_gnt        = GNT_IO;
         w_pop        = 1'b1;
         starve_cnt_d = '0;
      end else if (starve_cnt_q < c_STARVE_MAX) begin
         w_gnt        = GNT_CPU;
         starve_cnt_d = starve_cnt_q + 1'b1;
      end else begin
         w_gnt        = GNT_IO;
         w_pop        = 1'b1;
         w_stall      = 1'b1;
         starve_cnt_d = '0;
      end
   end

   // Write-port mux; outputs are held at zero while reset is asserted
   always_comb begin
      rf_we     = 1'b0;
      rf_wa     = cpu_wa;
      rf_wd     = cpu_wd;
      cpu_stall = 1'b0;
      if (reset) begin
         rf_wa = '0;
         rf_wd = '0;
      end else begin
         case (w_gnt)
            GNT_CPU: begin
               rf_we = 1'b1;
            end
            GNT_IO: begin
               rf_we     = 1'b1;
               rf_wa     = w_head[c_ENTRY_W-1:DATA_W];
               rf_wd     = w_head[DATA_W-1:0];
               cpu_stall = w_stall;
            end
            default: begin
               rf_we = 1'b0;
            end
         endcase
      end
   end

   // Starvation counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

`ifdef RF_ARB_STATS_EN
   logic [15:0] stat_cpu_wr_q;
   logic [15:0] stat_io_wr_q;
   logic [15:0] stat_stall_q;

   assign stat_cpu_wr = stat_cpu_wr_q;
   assign stat_io_wr  = stat_io_wr_q;
   assign stat_stall  = stat_stall_q;

   // Saturating activity counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_cpu_wr_q <= '0;
         stat_io_wr_q  <= '0;
         stat_stall_q  <= '0;
      end else begin
         if ((w_gnt == GNT_CPU) && (stat_cpu_wr_q != 16'hFFFF)) begin
            stat_cpu_wr_q <= stat_cpu_wr_q + 16'd1;
         end
         if (w_pop && (stat_io_wr_q != 16'hFFFF)) begin
            stat_io_wr_q <= stat_io_wr_q + 16'd1;
         end
         if (w_stall && (stat_stall_q != 16'hFFFF)) begin
            stat_stall_q <= stat_stall_q + 16'd1;
         end
      end
   end
`endif

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Brief    : Self-checking bench for rf_write_arbiter with a queue-based
//            reference model of the grant rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

   localparam int DEPTH = 4;
   localparam int SMAX  = 3;
   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_we;
   logic [AW-1:0] cpu_wa;
   logic [DW-1:0] cpu_wd;
   logic          cpu_stall;
   logic          io_valid;
   logic          io_ready;
   logic [AW-1:0] io_wa;
   logic [DW-1:0] io_wd;
   logic          rf_we;
   logic [AW-1:0] rf_wa;
   logic [DW-1:0] rf_wd;
   logic [CW-1:0] fifo_count;
`ifdef RF_ARB_STATS_EN
   logic [15:0]   stat_cpu_wr;
   logic [15:0]   stat_io_wr;
   logic [15:0]   stat_stall;
`endif

   int total = 0;
   int bad   = 0;

   rf_write_arbiter #(
      .FIFO_DEPTH (DEPTH),
      .STARVE_MAX (SMAX),
      .ADDR_W     (AW),
      .DATA_W     (DW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_we     (cpu_we),
      .cpu_wa     (cpu_wa),
      .cpu_wd     (cpu_wd),
      .cpu_stall  (cpu_stall),
      .io_valid   (io_valid),
      .io_ready   (io_ready),
      .io_wa      (io_wa),
      .io_wd      (io_wd),
      .rf_we      (rf_we),
      .rf_wa      (rf_wa),
      .rf_wd      (rf_wd),
      .fifo_count (fifo_count)
`ifdef RF_ARB_STATS_EN
      ,
      .stat_cpu_wr (stat_cpu_wr),
      .stat_io_wr  (stat_io_wr),
      .stat_stall  (stat_stall)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: pending I/O writes as a queue, starvation as an integer
   typedef struct packed {
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
   } ent_t;

   ent_t          mq[$];
   int            m_starve;
   int            m_cpu_wr;
   int            m_io_wr;
   int            m_stall;
   logic          e_we, e_stall, e_ready, e_pop, e_push, e_cpu;
   logic [AW-1:0] e_wa;
   logic [DW-1:0] e_wd;

   function automatic void model_reset();
      mq.delete();
      m_starve = 0;
      m_cpu_wr = 0;
      m_io_wr  = 0;
      m_stall  = 0;
   endfunction

   // Expected outputs for the current inputs and model state
   function automatic void predict();
      e_ready = (mq.size() < DEPTH);
      e_push  = io_valid && e_ready && (io_wa != '0);
      e_pop   = 1'b0;
      e_stall = 1'b0;
      e_cpu   = 1'b0;
      e_we    = cpu_we;
      e_wa    = cpu_wa;
      e_wd    = cpu_wd;
      if (mq.size() == 0) begin
         e_cpu = cpu_we;
      end else if (!cpu_we || m_starve >= SMAX) begin
         e_pop   = 1'b1;
         e_we    = 1'b1;
         e_wa    = mq[0].wa;
         e_wd    = mq[0].wd;
         e_stall = cpu_we;
      end else begin
         e_cpu = 1'b1;
      end
   endfunction

   // Advance DUT and model by one clock edge
   task automatic tick();
      ent_t e;
      @(posedge clk);
      if (e_cpu)   m_cpu_wr++;
      if (e_pop)   m_io_wr++;
      if (e_stall) m_stall++;
      if (mq.size() == 0 || e_pop) m_starve = 0;
      else                         m_starve++;
      if (e_pop) void'(mq.pop_front());
      if (e_push) begin
         e.wa = io_wa;
         e.wd = io_wd;
         mq.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; cpu_we = 1'b0; cpu_wa = '0; cpu_wd = '0;
      io_valid = 1'b1; io_wa = 4'd7; io_wd = 8'hAA;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      total++; if (io_ready !== 1'b1) begin bad++; $display("FAIL reset_io_ready got=%b want=1", io_ready); end
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b want=0", rf_we); end
      total++; if (fifo_count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", cpu_stall); end
      total++; if (rf_wa !== '0 || rf_wd !== '0) begin bad++; $display("FAIL reset_rf_addr_data got=%0h/%0h want=0/0", rf_wa, rf_wd); end
      io_valid = 1'b0;
      reset = 1'b0;
      #1;
      total++; if (io_ready !== 1'b1) begin bad++; $display("FAIL post_reset_io_ready got=%b want=1", io_ready); end
      @(negedge clk);
   endtask

   task automatic test_drain();
      cpu_we = 1'b0; io_valid = 1'b1; io_wa = 4'd5; io_wd = 8'h3C;
      #1; predict();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL drain_no_bypass got=%b want=0", rf_we); end
      tick();
      io_valid = 1'b0;
      #1; predict();
      total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL drain_we got=%b want=1", rf_we); end
      total++; if (rf_wa !== 4'd5 || rf_wd !== 8'h3C) begin bad++; $display("FAIL drain_entry got=%0h/%0h want=5/3c", rf_wa, rf_wd); end
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL drain_stall got=%b want=0", cpu_stall); end
      tick();
      #1;
      total++; if (fifo_count !== '0) begin bad++; $display("FAIL drain_count got=%0d want=0", fifo_count); end
   endtask

   task automatic test_force();
      cpu_we = 1'b1; cpu_wa = 4'd4; cpu_wd = 8'h5A;
      io_valid = 1'b1; io_wa = 4'd2; io_wd = 8'h11;
      #1; predict(); tick();
      io_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         #1; predict();
         if (c == 4) begin
            total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL force_stall cyc=%0d got=%b want=1", c, cpu_stall); end
            total++; if (rf_we !== 1'b1 || rf_wa !== 4'd2 || rf_wd !== 8'h11) begin bad++; $display("FAIL force_entry got=%b/%0h/%0h want=1/2/11", rf_we, rf_wa, rf_wd); end
         end else begin
            total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL force_nostall cyc=%0d got=%b want=0", c, cpu_stall); end
            total++; if (rf_we !== 1'b1 || rf_wa !== 4'd4 || rf_wd !== 8'h5A) begin bad++; $display("FAIL force_cpu cyc=%0d got=%b/%0h/%0h want=1/4/5a", c, rf_we, rf_wa, rf_wd); end
         end
         tick();
      end
      #1;
      total++; if (fifo_count !== '0) begin bad++; $display("FAIL force_count got=%0d want=0", fifo_count); end
   endtask

   task automatic test_full();
      cpu_we = 1'b1; cpu_wa = 4'd9; cpu_wd = 8'h77; io_valid = 1'b1;
      for (int c = 0; c <= 4; c++) begin
         io_wa = 4'(c + 1);
         io_wd = 8'(8'h40 + c);
         #1; predict();
         total++; if (fifo_count !== CW'(c)) begin bad++; $display("FAIL full_count cyc=%0d got=%0d want=%0d", c, fifo_count, c); end
         if (c < 4) begin
            total++; if (io_ready !== 1'b1 || cpu_stall !== 1'b0) begin bad++; $display("FAIL full_fill cyc=%0d got=%b/%b want=1/0", c, io_ready, cpu_stall); end
         end else begin
            total++; if (io_ready !== 1'b0) begin bad++; $display("FAIL full_io_ready got=%b want=0", io_ready); end
            total++; if (cpu_stall !== 1'b1 || rf_wa !== 4'd1) begin bad++; $display("FAIL full_force got=%b/%0h want=1/1", cpu_stall, rf_wa); end
         end
         tick();
      end
      io_valid = 1'b0;
      #1; predict();
      total++; if (fifo_count !== CW'(3)) begin bad++; $display("FAIL full_no_admit got=%0d want=3", fifo_count); end
      total++; if (rf_wa !== 4'd9 || cpu_stall !== 1'b0) begin bad++; $display("FAIL full_cpu_after_stall got=%0h/%b want=9/0", rf_wa, cpu_stall); end
      tick();
      cpu_we = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1; predict();
         total++; if (rf_we !== 1'b1 || rf_wa !== 4'(c + 2) || rf_wd !== 8'(8'h41 + c)) begin bad++; $display("FAIL full_order idx=%0d got=%b/%0h/%0h want=1/%0h/%0h", c, rf_we, rf_wa, rf_wd, c + 2, 8'h41 + c); end
         tick();
      end
   endtask

   task automatic test_r0_discard();
      cpu_we = 1'b0; io_valid = 1'b1; io_wa = 4'd0; io_wd = 8'hFF;
      #1; predict();
      total++; if (io_ready !== 1'b1) begin bad++; $display("FAIL r0_ready got=%b want=1", io_ready); end
      tick();
      io_valid = 1'b0;
      #1; predict();
      total++; if (fifo_count !== '0 || rf_we !== 1'b0) begin bad++; $display("FAIL r0_discard got=%0d/%b want=0/0", fifo_count, rf_we); end
      tick();
   endtask

   task automatic test_reset_flush();
      cpu_we = 1'b1; cpu_wa = 4'd3; cpu_wd = 8'h21; io_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         io_wa = 4'(6 + c);
         io_wd = 8'(8'h90 + c);
         #1; predict(); tick();
      end
      io_valid = 1'b0;
      #1;
      total++; if (fifo_count !== CW'(3)) begin bad++; $display("FAIL flush_prefill got=%0d want=3", fifo_count); end
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      total++; if (fifo_count !== '0 || rf_we !== 1'b0) begin bad++; $display("FAIL flush_immediate got=%0d/%b want=0/0", fifo_count, rf_we); end
      @(negedge clk);
      reset = 1'b0;
      cpu_we = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1; predict();
         total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL flush_no_write cyc=%0d got=%b want=0", c, rf_we); end
         tick();
      end
   endtask

   task automatic test_random();
      logic held;
      held = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!held) begin
            cpu_we = ($urandom_range(0, 99) < 60);
            cpu_wa = 4'($urandom);
            cpu_wd = 8'($urandom);
         end
         io_valid = ($urandom_range(0, 99) < 45);
         io_wa    = 4'($urandom);
         io_wd    = 8'($urandom);
         #1; predict();
         total++; if (rf_we !== e_we) begin bad++; $display("FAIL rnd_we n=%0d got=%b want=%b", n, rf_we, e_we); end
         if (e_we) begin
            total++; if (rf_wa !== e_wa || rf_wd !== e_wd) begin bad++; $display("FAIL rnd_entry n=%0d got=%0h/%0h want=%0h/%0h", n, rf_wa, rf_wd, e_wa, e_wd); end
         end
         total++; if (cpu_stall !== e_stall) begin bad++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, cpu_stall, e_stall); end
         if (held) begin
            total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rnd_double_stall n=%0d got=%b want=0", n, cpu_stall); end
         end
         total++; if (io_ready !== e_ready) begin bad++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, io_ready, e_ready); end
         total++; if (fifo_count !== CW'(mq.size())) begin bad++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, fifo_count, mq.size()); end
         held = e_stall;
         tick();
      end
`ifdef RF_ARB_STATS_EN
      #1;
      total++; if (stat_cpu_wr !== 16'(m_cpu_wr)) begin bad++; $display("FAIL stat_cpu_wr got=%0d want=%0d", stat_cpu_wr, m_cpu_wr); end
      total++; if (stat_io_wr !== 16'(m_io_wr)) begin bad++; $display("FAIL stat_io_wr got=%0d want=%0d", stat_io_wr, m_io_wr); end
      total++; if (stat_stall !== 16'(m_stall)) begin bad++; $display("FAIL stat_stall got=%0d want=%0d", stat_stall, m_stall); end
`endif
   endtask

   initial begin
      test_reset();
      test_drain();
      test_force();
      test_full();
      test_r0_discard();
      test_reset_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rf_write_arbiter
`default_nettype wire
